// File: rtl/renkon_pkg.sv
// Shared definitions for the renkon pooling path: edge-length width,
// channel-sequencer states and the default feature-memory read latency.
package renkon_pkg;

  localparam int LWIDTH    = 10;
  localparam int D_MEM_DEF = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BEGIN = 3'd1,
    S_READ  = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/pool_sched_dly.sv
// Fixed-depth shift register that re-times the {read-enable, last-pixel}
// pair so it lines up with data returning from the feature memory.
module pool_sched_dly #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             xrst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/pool_sched.sv
// Channel-level sequencer for the pooling controller: per map it pulses
// in_begin, streams linear feature reads and waits for out_end.
// Optional build macro POOL_SCHED_PERF_EN adds the perf_cycles busy counter.
module pool_sched
  import renkon_pkg::*;
#(
  parameter int CWIDTH = 10,
  parameter int AWIDTH = 16,
  parameter int D_MEM  = D_MEM_DEF
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              req,
  input  logic [CWIDTH-1:0] n_chan,
  input  logic [LWIDTH-1:0] fea_size,
  input  logic [LWIDTH-1:0] pool_size,
  input  logic [AWIDTH-1:0] feat_base,
  input  logic [AWIDTH-1:0] out_base,
  output logic              ack,
  output logic              busy,
  output logic              mem_feat_re,
  output logic [AWIDTH-1:0] mem_feat_addr,
  output logic              in_begin,
  output logic              in_valid,
  output logic              in_end,
  output logic [LWIDTH-1:0] w_fea_size,
  output logic [LWIDTH-1:0] w_pool_size,
  input  logic              out_valid,
  input  logic              out_end,
  output logic              mem_out_we,
`ifdef POOL_SCHED_PERF_EN
  output logic [31:0]       perf_cycles,
`endif
  output logic [AWIDTH-1:0] mem_out_addr
);

  localparam int FW = 2 * LWIDTH;

  state_e            r_state;
  state_e            w_next;
  logic              r_busy;
  logic [CWIDTH-1:0] r_nChan;
  logic [CWIDTH-1:0] r_chan;
  logic [LWIDTH-1:0] r_feaSize;
  logic [LWIDTH-1:0] r_poolSize;
  logic [FW-1:0]     r_frame;
  logic [FW-1:0]     r_pix;
  logic [AWIDTH-1:0] r_featAddr;
  logic [AWIDTH-1:0] r_outAddr;
  logic              r_outWe;

  logic w_accept;
  logic w_empty;
  logic w_lastPix;
  logic w_lastChan;
  logic w_reading;

  assign w_accept   = (r_state == S_IDLE) && req;
  assign w_empty    = (n_chan == '0) || (fea_size == '0);
  assign w_lastPix  = (r_pix == r_frame - FW'(1));
  assign w_lastChan = (r_chan == r_nChan - CWIDTH'(1));
  assign w_reading  = (r_state == S_READ);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req) w_next = w_empty ? S_DONE : S_BEGIN;
      S_BEGIN: w_next = S_READ;
      S_READ:  if (w_lastPix) w_next = S_WAIT;
      S_WAIT:  if (out_end) w_next = w_lastChan ? S_DONE : S_BEGIN;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Job parameters are captured only on an accepted request; the read
  // address keeps running across maps so the maps stay contiguous.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_nChan    <= '0;
      r_chan     <= '0;
      r_feaSize  <= '0;
      r_poolSize <= '0;
      r_frame    <= '0;
      r_pix      <= '0;
      r_featAddr <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      if (w_accept) begin
        r_nChan    <= n_chan;
        r_feaSize  <= fea_size;
        r_poolSize <= pool_size;
        r_frame    <= FW'(fea_size) * FW'(fea_size);
        r_chan     <= '0;
        r_pix      <= '0;
        r_featAddr <= feat_base;
      end else begin
        if (w_reading) begin
          r_featAddr <= r_featAddr + AWIDTH'(1);
          r_pix      <= w_lastPix ? '0 : r_pix + FW'(1);
        end
        if ((r_state == S_WAIT) && out_end && !w_lastChan) r_chan <= r_chan + CWIDTH'(1);
      end
    end
  end

  // The write address advances after each issued write, so it is valid
  // alongside mem_out_we for the current result.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_outWe   <= 1'b0;
      r_outAddr <= '0;
    end else begin
      r_outWe <= out_valid;
      if (w_accept) r_outAddr <= out_base;
      else if (r_outWe) r_outAddr <= r_outAddr + AWIDTH'(1);
    end
  end

  pool_sched_dly #(
    .DEPTH(D_MEM),
    .WIDTH(2)
  ) u_dly (
    .clk (clk),
    .xrst(xrst),
    .i_d ({w_reading, w_reading && w_lastPix}),
    .o_q ({in_valid, in_end})
  );

`ifdef POOL_SCHED_PERF_EN
  logic [31:0] r_perf;

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_perf <= '0;
    end else if (w_accept) begin
      r_perf <= '0;
    end else if (r_busy && (r_perf != 32'hFFFF_FFFF)) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_cycles = r_perf;
`endif

  assign ack           = (r_state == S_DONE);
  assign busy          = r_busy;
  assign mem_feat_re   = w_reading;
  assign mem_feat_addr = r_featAddr;
  assign in_begin      = (r_state == S_BEGIN);
  assign w_fea_size    = r_feaSize;
  assign w_pool_size   = r_poolSize;
  assign mem_out_we    = r_outWe;
  assign mem_out_addr  = r_outAddr;

endmodule
